// File: rtl/vape_region_file.sv
// vape_region_file: VAPE metadata peripheral with region registers, a challenge buffer and an exec-driven lock.
//
// Ports:
//   mclk        main clock
//   puc_rst     asynchronous active-high reset
//   per_addr    peripheral word address
//   per_din     write data
//   per_en      access enable
//   per_we      byte write enables ([0] low, [1] high); 00 is a read
//   exec_flag   execution flag from the monitor
//   per_dout    combinational read data, 0 when not selected or on a write
//   region_min  packed region minimum addresses, region i at [16i+15:16i]
//   region_max  packed region maximum addresses, same packing
//   exec_q      exec_flag registered once
//   lock        metadata frozen (state other than UNLOCKED)
//   viol        one-cycle pulse after a blocked write
//   chal_valid  every challenge word written since the last clear
module vape_region_file #(
    parameter logic [14:0] BASE_ADDR   = 15'h0160,
    parameter int          DEC_WD      = 3,
    parameter int          NUM_REGIONS = 2,
    parameter logic [13:0] CHAL_BASE   = 14'h0a0,
    parameter int          CHAL_WORDS  = 16
) (
    input  logic                      mclk,
    input  logic                      puc_rst,
    input  logic [13:0]               per_addr,
    input  logic [15:0]               per_din,
    input  logic                      per_en,
    input  logic [1:0]                per_we,
    input  logic                      exec_flag,
    output logic [15:0]               per_dout,
    output logic [16*NUM_REGIONS-1:0] region_min,
    output logic [16*NUM_REGIONS-1:0] region_max,
    output logic                      exec_q,
    output logic                      lock,
    output logic                      viol,
    output logic                      chal_valid
);

    localparam int                IW       = (CHAL_WORDS > 1) ? $clog2(CHAL_WORDS) : 1;
    localparam logic [DEC_WD-1:0] K_STAT   = DEC_WD'(2 * NUM_REGIONS);
    localparam logic [DEC_WD-1:0] K_CTRL   = DEC_WD'(2 * NUM_REGIONS + 1);
    localparam logic [14:0]       CHAL_END = 15'(CHAL_BASE) + 15'(CHAL_WORDS);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ARMED    = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [15:0]           rmin [NUM_REGIONS];
    logic [15:0]           rmax [NUM_REGIONS];
    logic [15:0]           chal [CHAL_WORDS];
    logic [CHAL_WORDS-1:0] mask;
    logic                  sticky;

    logic [DEC_WD-1:0] k;
    logic [IW-1:0]     chal_idx;
    logic              win_sel, chal_sel, wr, rd;
    logic              reg_wr, chal_wr, ctrl_wr;
    logic              arm, disarm, clr;
    logic              exec_rise, exec_fall, blocked;

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] din,
                                          input logic [1:0] we);
        return {we[1] ? din[15:8] : old[15:8], we[0] ? din[7:0] : old[7:0]};
    endfunction

    // Address decode
    assign k         = per_addr[DEC_WD-1:0];
    assign win_sel   = per_en && (per_addr[13:DEC_WD] == BASE_ADDR[14:DEC_WD+1]);
    assign chal_sel  = per_en && ({1'b0, per_addr} >= 15'(CHAL_BASE)) && ({1'b0, per_addr} < CHAL_END);
    assign chal_idx  = IW'(per_addr - CHAL_BASE);
    assign wr        = |per_we;
    assign rd        = per_en && (per_we == 2'b00);
    assign reg_wr    = win_sel && wr && (k < K_STAT);
    assign chal_wr   = chal_sel && wr;
    // CTRL bits live in the low byte, so only a low-byte write can command it
    assign ctrl_wr   = win_sel && per_we[0] && (k == K_CTRL);
    assign arm       = ctrl_wr && per_din[0];
    assign disarm    = ctrl_wr && per_din[1];
    assign clr       = ctrl_wr && per_din[2];
    assign exec_rise = exec_flag && !exec_q;
    assign exec_fall = !exec_flag && exec_q;

    // State register
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst)
            state <= UNLOCKED;
        else
            state <= state_nx;
    end

    // Next state: exec edges take priority over CTRL commands
    always_comb begin
        state_nx = state;
        case (state)
            UNLOCKED: state_nx = exec_rise ? LOCKED : (arm ? ARMED : UNLOCKED);
            ARMED:    state_nx = exec_rise ? LOCKED : (disarm ? UNLOCKED : ARMED);
            LOCKED:   state_nx = exec_fall ? UNLOCKED : LOCKED;
            default:  state_nx = UNLOCKED;
        endcase
    end

    // Outputs of the lock FSM; acceptance is judged on the pre-edge state
    always_comb begin
        lock    = (state != UNLOCKED);
        blocked = (reg_wr || chal_wr) && lock;
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                rmin[i] <= '0;
                rmax[i] <= '0;
            end
        end else if (reg_wr && !lock) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (k == DEC_WD'(2 * i))
                    rmin[i] <= merge(rmin[i], per_din, per_we);
                if (k == DEC_WD'(2 * i + 1))
                    rmax[i] <= merge(rmax[i], per_din, per_we);
            end
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            for (int j = 0; j < CHAL_WORDS; j++)
                chal[j] <= '0;
        end else if (chal_wr && !lock) begin
            chal[chal_idx] <= merge(chal[chal_idx], per_din, per_we);
        end
    end

    // Completeness mask; cleared when execution ends so a challenge is used once
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst)
            mask <= '0;
        else if (exec_fall)
            mask <= '0;
        else if (chal_wr && !lock)
            mask[chal_idx] <= 1'b1;
    end

    // Setting the sticky flag wins over a same-cycle clear
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            exec_q <= 1'b0;
            viol   <= 1'b0;
            sticky <= 1'b0;
        end else begin
            exec_q <= exec_flag;
            viol   <= blocked;
            sticky <= blocked || (sticky && !(clr && !lock));
        end
    end

    assign chal_valid = &mask;

    always_comb begin
        per_dout = '0;
        if (win_sel && rd) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (k == DEC_WD'(2 * i))
                    per_dout = rmin[i];
                if (k == DEC_WD'(2 * i + 1))
                    per_dout = rmax[i];
            end
            if (k == K_STAT)
                per_dout = {12'b0, chal_valid, sticky, lock, exec_q};
        end
        if (chal_sel && rd)
            per_dout = per_dout | chal[chal_idx];
    end

    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_pack
        assign region_min[16*i +: 16] = rmin[i];
        assign region_max[16*i +: 16] = rmax[i];
    end

endmodule

// File: tb/tb_vape_region_file.sv
// tb_vape_region_file: directed self-checking bench for vape_region_file against a behavioural model.
module tb_vape_region_file;

    logic        mclk = 1'b0;
    logic        puc_rst = 1'b1;
    logic [13:0] per_addr = '0;
    logic [15:0] per_din = '0;
    logic        per_en = 1'b0;
    logic [1:0]  per_we = 2'b00;
    logic        exec_flag = 1'b0;
    logic [15:0] per_dout;
    logic [31:0] region_min, region_max;
    logic        exec_q, lock, viol, chal_valid;

    int n_tests = 0;
    int n_fail  = 0;

    vape_region_file dut (
        .mclk(mclk), .puc_rst(puc_rst), .per_addr(per_addr), .per_din(per_din),
        .per_en(per_en), .per_we(per_we), .exec_flag(exec_flag), .per_dout(per_dout),
        .region_min(region_min), .region_max(region_max), .exec_q(exec_q), .lock(lock),
        .viol(viol), .chal_valid(chal_valid)
    );

    always #5 mclk = ~mclk;

    // Behavioural model: what the peripheral must hold after each clock
    logic [15:0] m_min [2];
    logic [15:0] m_max [2];
    logic [15:0] m_chal [16];
    logic [15:0] m_mask = '0;
    int          m_mode = 0;   // 0 free, 1 armed, 2 frozen by execution
    logic        m_sticky = 1'b0, m_viol = 1'b0, m_exq = 1'b0;

    function automatic logic [15:0] put_bytes(input logic [15:0] old, input logic [15:0] nw,
                                              input logic [1:0] we);
        logic [15:0] r;
        r = old;
        if (we[0]) r[7:0] = nw[7:0];
        if (we[1]) r[15:8] = nw[15:8];
        return r;
    endfunction

    task automatic model_step();
        logic wr_any, in_win, in_chal, blk, arm, dis, clr, rise, fall;
        int off, ci;
        if (puc_rst) begin
            for (int i = 0; i < 2; i++) begin m_min[i] = '0; m_max[i] = '0; end
            for (int i = 0; i < 16; i++) m_chal[i] = '0;
            m_mask = '0; m_mode = 0; m_sticky = 0; m_viol = 0; m_exq = 0;
            return;
        end
        wr_any  = per_en && (per_we != 2'b00);
        in_win  = per_en && (per_addr >= 14'h0b0) && (per_addr < 14'h0b8);
        in_chal = per_en && (per_addr >= 14'h0a0) && (per_addr < 14'h0b0);
        off     = int'(per_addr) - 'hb0;
        ci      = int'(per_addr) - 'ha0;
        blk     = 1'b0;
        if (wr_any && in_win && off < 4) begin
            if (m_mode != 0) blk = 1'b1;
            else if (off % 2 == 0) m_min[off/2] = put_bytes(m_min[off/2], per_din, per_we);
            else m_max[off/2] = put_bytes(m_max[off/2], per_din, per_we);
        end
        if (wr_any && in_chal) begin
            if (m_mode != 0) blk = 1'b1;
            else begin
                m_chal[ci] = put_bytes(m_chal[ci], per_din, per_we);
                m_mask[ci] = 1'b1;
            end
        end
        arm  = in_win && off == 5 && per_we[0] && per_din[0];
        dis  = in_win && off == 5 && per_we[0] && per_din[1];
        clr  = in_win && off == 5 && per_we[0] && per_din[2];
        rise = exec_flag && !m_exq;
        fall = !exec_flag && m_exq;
        if (blk) m_sticky = 1'b1;
        else if (clr && m_mode == 0) m_sticky = 1'b0;
        if (m_mode == 2) begin
            if (fall) m_mode = 0;
        end else if (rise) m_mode = 2;
        else if (m_mode == 0 && arm) m_mode = 1;
        else if (m_mode == 1 && dis) m_mode = 0;
        if (fall) m_mask = '0;
        m_viol = blk;
        m_exq  = exec_flag;
    endtask

    initial forever begin
        @(posedge mclk or posedge puc_rst);
        model_step();
    end

    function automatic logic [15:0] m_read();
        logic [15:0] r;
        int off, ci;
        r = '0;
        if (!(per_en && per_we == 2'b00)) return r;
        off = int'(per_addr) - 'hb0;
        ci  = int'(per_addr) - 'ha0;
        if (per_addr >= 14'h0b0 && per_addr < 14'h0b8) begin
            if (off < 4) r = (off % 2 == 0) ? m_min[off/2] : m_max[off/2];
            if (off == 4) r = {12'b0, &m_mask, m_sticky, m_mode != 0, m_exq};
        end
        if (per_addr >= 14'h0a0 && per_addr < 14'h0b0) r = m_chal[ci];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Per-cycle comparison of every registered output against the model
    always @(negedge mclk) begin
        if (!puc_rst) begin
            check("region_min", region_min, {m_min[1], m_min[0]});
            check("region_max", region_max, {m_max[1], m_max[0]});
            check("exec_q", {31'b0, exec_q}, {31'b0, m_exq});
            check("lock", {31'b0, lock}, {31'b0, m_mode != 0});
            check("viol", {31'b0, viol}, {31'b0, m_viol});
            check("chal_valid", {31'b0, chal_valid}, {31'b0, &m_mask});
        end
    end

    task automatic acc(input logic en, input logic [1:0] we, input logic [13:0] a, input logic [15:0] d);
        @(negedge mclk);
        per_en = en; per_we = we; per_addr = a; per_din = d;
    endtask

    task automatic wr(input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
        acc(1'b1, we, a, d);
    endtask

    task automatic idle();
        acc(1'b0, 2'b00, 14'h0, 16'h0);
        #1;
    endtask

    task automatic rd(input logic [13:0] a, input string name, input logic [15:0] exp);
        acc(1'b1, 2'b00, a, 16'h0);
        #1;
        check({name, "_model"}, {16'b0, per_dout}, {16'b0, m_read()});
        check(name, {16'b0, per_dout}, {16'b0, exp});
    endtask

    initial begin
        repeat (2) @(negedge mclk);
        #1;
        check("rst_outputs", {region_min, region_max}, 64'h0);
        check("rst_flags", {28'b0, exec_q, lock, viol, chal_valid}, 32'h0);
        @(negedge mclk);
        puc_rst = 1'b0;
        for (int i = 0; i < 8; i++) rd(14'(14'h0b0 + i), "rd_reset", 16'h0);
        rd(14'h0a5, "rd_chal_reset", 16'h0);

        // Region writes and byte enables
        wr(14'h0b1, 16'h1234, 2'b11);
        wr(14'h0b2, 16'h8000, 2'b11);
        idle();
        check("rmin1_8000", {16'b0, region_min[31:16]}, 32'h8000);
        check("rmax0_kept", {16'b0, region_max[15:0]}, 32'h1234);
        wr(14'h0b1, 16'habcd, 2'b01);
        idle();
        check("rmax0_lowbyte", {16'b0, region_max[15:0]}, 32'h12cd);
        wr(14'h0b3, 16'hbeef, 2'b10);
        idle();
        check("rmax1_highbyte", {16'b0, region_max[31:16]}, 32'hbe00);
        rd(14'h0b5, "rd_ctrl", 16'h0);

        // ARM, blocked write, DISARM, clear
        wr(14'h0b5, 16'h0001, 2'b11);
        idle();
        check("armed_lock", {31'b0, lock}, 32'h1);
        wr(14'h0b0, 16'h5555, 2'b11);
        idle();
        check("armed_viol", {31'b0, viol}, 32'h1);
        check("armed_rmin0", {16'b0, region_min[15:0]}, 32'h0);
        idle();
        check("viol_oneshot", {31'b0, viol}, 32'h0);
        rd(14'h0b4, "status_armed", 16'h0006);
        wr(14'h0b5, 16'h0002, 2'b11);
        idle();
        check("disarm_lock", {31'b0, lock}, 32'h0);
        wr(14'h0b5, 16'h0004, 2'b11);
        rd(14'h0b4, "status_cleared", 16'h0000);

        // Challenge fill, lock by execution, single-use invalidation
        for (int i = 0; i < 15; i++) wr(14'(14'h0a0 + i), 16'(i * 16'h1111) ^ 16'h5a5a, 2'b11);
        idle();
        check("chal_partial", {31'b0, chal_valid}, 32'h0);
        wr(14'h0af, 16'h0f0f, 2'b11);
        idle();
        check("chal_full", {31'b0, chal_valid}, 32'h1);
        exec_flag = 1'b1;
        idle();
        check("exec_lock", {30'b0, exec_q, lock}, 32'h3);
        wr(14'h0a3, 16'hffff, 2'b11);
        idle();
        check("chal_blocked_viol", {31'b0, viol}, 32'h1);
        rd(14'h0a3, "chal_kept_locked", 16'h6969);
        wr(14'h0b5, 16'h0006, 2'b11);
        idle();
        check("ctrl_ignored_locked", {31'b0, lock}, 32'h1);
        rd(14'h0b4, "status_locked", 16'h000f);
        exec_flag = 1'b0;
        idle();
        check("exec_fall_unlock", {30'b0, lock, chal_valid}, 32'h0);
        rd(14'h0a3, "chal_kept_after", 16'h6969);
        rd(14'h0b4, "status_sticky", 16'h0004);
        wr(14'h0b5, 16'h0004, 2'b01);
        rd(14'h0b4, "status_clr", 16'h0000);

        // Write in the cycle of the exec rise is accepted, the next is blocked
        wr(14'h0b3, 16'h7777, 2'b11);
        exec_flag = 1'b1;
        wr(14'h0b3, 16'h9999, 2'b11);
        idle();
        check("rise_cycle_accepted", {16'b0, region_max[31:16]}, 32'h7777);
        check("next_cycle_blocked", {30'b0, lock, viol}, 32'h3);

        // Asynchronous reset while LOCKED with sticky set
        @(negedge mclk);
        puc_rst = 1'b1;
        per_en = 1'b1; per_we = 2'b00; per_addr = 14'h0b4;
        #1;
        check("arst_regions", {region_min, region_max}, 64'h0);
        check("arst_flags", {28'b0, exec_q, lock, viol, chal_valid}, 32'h0);
        check("arst_status", {16'b0, per_dout}, 32'h0);
        @(negedge mclk);
        puc_rst = 1'b0;
        idle();
        check("relock_after_reset", {30'b0, exec_q, lock}, 32'h3);
        rd(14'h0b4, "status_after_reset", 16'h0003);
        exec_flag = 1'b0;
        idle();
        idle();
        check("unlock_after_reset", {31'b0, lock}, 32'h0);
        rd(14'h0b3, "rmax1_after_reset", 16'h0000);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vape_region_file.md
# vape_region_file

Parametrised VAPE metadata peripheral on the openMSP430 peripheral bus. It holds NUM_REGIONS min/max address-region pairs and a CHAL_WORDS×16 challenge buffer, and samples the execution flag. A lock state machine freezes all metadata from arming until execution ends, flags blocked write attempts, and tracks challenge completeness with single-use invalidation.

## Interface
- BASE_ADDR, 15'h0160, byte base of the register window; aligned to 2^(DEC_WD+1) bytes.
- DEC_WD, 3, word-offset decoder width; 2*NUM_REGIONS+2 ≤ 2^DEC_WD.
- NUM_REGIONS, 2, number of min/max pairs; region 0 = ER, region 1 = OR.
- CHAL_BASE, 14'h0a0, word address of challenge word 0.
- CHAL_WORDS, 16, challenge depth in 16-bit words; range 1..64.
- mclk  in  1  main clock.
- puc_rst  in  1  asynchronous, active-high reset.
- per_addr  in  14  peripheral word address.
- per_din  in  16  write data.
- per_en  in  1  access enable.
- per_we  in  2  byte write enables: [0] low byte, [1] high byte; 00 = read.
- exec_flag  in  1  execution flag from the monitor.
- per_dout  out  16  read data, combinational; 0 when not selected or on a write.
- region_min  out  16*NUM_REGIONS  region i min at bits [16i+15:16i].
- region_max  out  16*NUM_REGIONS  region i max, same packing.
- exec_q  out  1  exec_flag registered once.
- lock  out  1  high when state ≠ UNLOCKED.
- viol  out  1  one-cycle pulse on a blocked write.
- chal_valid  out  1  every challenge word written since the last clear.

## Operation
- Window select: per_en & per_addr[13:DEC_WD]==BASE_ADDR[14:DEC_WD+1].
- Word offset k = per_addr[DEC_WD-1:0].
- Offset map:
  - k=2i: region_min[i]; k=2i+1: region_max[i].
  - k=2N: STATUS, read-only: {12'b0, chal_valid, sticky_viol, lock, exec_q}.
  - k=2N+1: CTRL, write-only, reads 0. bit0 ARM, bit1 DISARM, bit2 CLR_VIOL.
  - Unmapped offsets read 0; writes to them are ignored.
- Challenge select: per_en & CHAL_BASE ≤ per_addr < CHAL_BASE+CHAL_WORDS; index = per_addr−CHAL_BASE.
- Region and challenge writes honour per_we per byte.
- States:
  - UNLOCKED: region and challenge writes accepted. ARM → ARMED. rise(exec) → LOCKED.
  - ARMED: rise(exec) → LOCKED. DISARM → UNLOCKED.
  - LOCKED: fall(exec) → UNLOCKED. CTRL ignored.
- rise(exec) = exec_flag & ~exec_q; fall(exec) = ~exec_flag & exec_q.
- Exec edges take priority over a same-cycle CTRL write.
- The current state (pre-edge) decides acceptance: a write in the cycle of rise(exec) while UNLOCKED is accepted.
- Blocked write: a region or challenge write with state ≠ UNLOCKED.
  - Data is unchanged.
  - viol pulses for 1 cycle and sticky_viol is set.
- CLR_VIOL clears sticky_viol only in UNLOCKED. Set wins over clear in the same cycle.
- Challenge mask (CHAL_WORDS bits):
  - An accepted challenge write with any per_we bit set marks that word.
  - chal_valid = &mask.
  - The mask clears on fall(exec): the challenge is single-use. Data is kept.
- Reads are allowed in every state.
- Reset: regions 0, challenge 0, exec_q 0, UNLOCKED, lock 0, viol 0, sticky 0, mask 0, chal_valid 0, per_dout 0.

## Timing
- Register, challenge, CTRL, and state updates occur on the mclk rising edge of the access cycle.
- Read data: per_dout is valid in the same cycle as per_en with per_we=00.
- region_min/max: change one cycle after an accepted write and are always registered.
- exec_q/lock: exec_q follows exec_flag with 1-cycle latency. lock rises at the same edge exec_q rises, or the edge after an ARM write.
- viol: high during the cycle after the blocked write.
- Reset: puc_rst mid-LOCKED returns the block to UNLOCKED immediately (asynchronous). The first clock after release samples exec_flag normally.

## Test plan
- Reset, then read all offsets → all 0. Write region_min[1]=16'h8000 with per_we=11 → region_max[0] unchanged, region_min[1]=16'h8000 the next cycle.
- Write 16'hABCD with per_we=01 to region_max[0] (previously 16'h1234) → 16'h12CD.
- CTRL=1 (ARM), then write region_min[0]=16'h5555 → value unchanged, viol pulses once, STATUS=16'h0006. CTRL=2 (DISARM) → lock=0.
- Write all CHAL_WORDS words → chal_valid=1 after the last write. Raise exec_flag → lock=1. Challenge write → blocked, viol. Drop exec_flag → UNLOCKED, chal_valid=0, challenge data kept.
- Write a region in the same cycle as the exec_flag rise (state UNLOCKED) → accepted. Write on the next cycle → blocked.
- Assert puc_rst while LOCKED with sticky_viol=1 → every output returns to 0 and state is UNLOCKED.
